seq_pattern_detector: RTL
=========================

Name: seq_pattern_detector

Overview:
- Parametrised serial bit-pattern detector.
- Generalises the fixed 2-bit Moore detector to a runtime-loadable pattern of PAT_W bits.
- Supports overlapping and non-overlapping match modes, input qualification, and a progress indication.
- Sits on a serial input stream and raises a registered one-cycle match pulse for downstream control logic.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..32.
- PAT_RESET, 4'b1011 (PAT_W bits), pattern register value after reset.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history discarded after each match.
- CNT_W, 8, width of the saturating match counter (optional feature only).

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  qualifies in_bit; bits with in_valid=0 are ignored.
- in_bit  in  1  serial data bit.
- cfg_load  in  1  one-cycle pulse; loads cfg_pattern and clears detection progress.
- cfg_pattern  in  PAT_W  new pattern; MSB is the first bit in time.
- match  out  1  registered pulse, high for one cycle per completed match.
- progress  out  $clog2(PAT_W+1)  number of valid bits held in history, saturating at PAT_W.
- match_count  out  CNT_W  saturating match counter (optional feature).
- cnt_clr  in  1  synchronous clear of match_count (optional feature).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - pattern register = PAT_RESET.
  - history = 0.
  - fill = 0, so progress = 0.
  - match = 0.
  - match_count = 0.
- Internal state:
  - pattern register, PAT_W bits.
  - history shift register, PAT_W bits; newest bit enters at the LSB.
  - fill counter, 0..PAT_W.
- Accepted bit: on a cycle with in_valid=1 and cfg_load=0, next = {history[PAT_W-2:0], in_bit}.
  - hit = (fill >= PAT_W-1) and (next == pattern).
- Registered update on an accepted bit:
  - match <= hit.
  - If hit and OVERLAP=0: history <= 0 and fill <= 0.
  - Otherwise: history <= next and fill <= min(fill+1, PAT_W).
- Latency: match is high in the cycle immediately after the edge on which the completing bit was accepted.
- in_valid=0: history and fill hold, and match <= 0. Gaps never break a partial match.
- cfg_load=1:
  - pattern <= cfg_pattern; history <= 0; fill <= 0; match <= 0.
  - A simultaneous in_valid bit is discarded, so cfg_load has priority.
- rst has priority over everything, including cfg_load and in_valid. Reset mid-sequence loses all progress.
- The pattern cannot change except via cfg_load or rst.
- Matching is never attempted with fill < PAT_W-1, so stale zeros in history cannot cause a false match on an all-zero pattern.
- progress = fill, combinationally from the register.

Optional Feature:
- Macro: SEQ_PATTERN_DETECTOR_MATCH_COUNT_EN.
- When defined:
  - match_count increments by 1 on every cycle in which match is being set to 1 (same edge as match).
  - The counter saturates at 2^CNT_W-1.
  - cnt_clr=1 clears it to 0; if cnt_clr and an increment coincide, the clear wins.
  - rst clears it.
  - cfg_load does not clear it.
- When undefined:
  - Both ports still exist.
  - match_count is tied to 0 and cnt_clr is ignored.
  - No counter flops are synthesised.

Test Plan:
- Reset value check: after rst, pattern stays 1011; idle the inputs -> match=0, progress=0, match_count=0.
- Overlap match: PAT_W=4, pattern 1011, OVERLAP=1, feed valid bits 1,0,1,1,0,1,1.
  - match pulses one cycle after the 4th bit and one cycle after the 7th bit.
  - match_count=2.
- Non-overlap and gaps: same stream with OVERLAP=0.
  - Single match after the 4th bit; progress reads 0 the next cycle, then 3 after the 7th bit; no second match.
  - Inserting in_valid=0 gaps of 1-5 cycles anywhere gives identical match timing relative to valid bits.
- Reload and reset mid-stream:
  - After bits 1,0,1, assert cfg_load with pattern 0000 and in_valid=1 on the same cycle -> that bit is dropped, progress=0.
  - Then four valid 0s -> match after the 4th; three 0s alone -> no match.
  - Assert rst after three pattern bits -> no match when the 4th bit arrives.
- Counter saturation: CNT_W=2, macro defined, force 5 matches -> match_count sequence 1,2,3,3,3.
  - cnt_clr together with a match -> 0.
  - With the macro undefined -> match_count stays 0 throughout.

Source files
------------

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: serial detector for a runtime-loadable PAT_W-bit pattern with a registered match pulse.
// Define SEQ_PATTERN_DETECTOR_MATCH_COUNT_EN to enable the saturating match_count counter.
module seq_pattern_detector #(
  parameter int PAT_W = 4,
  parameter logic [PAT_W-1:0] PAT_RESET = 4'b1011,
  parameter bit OVERLAP = 1'b1,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_bit,
  input  logic                       cfg_load,
  input  logic [PAT_W-1:0]           cfg_pattern,
  output logic                       match,
  output logic [$clog2(PAT_W+1)-1:0] progress,
  output logic [CNT_W-1:0]           match_count,
  input  logic                       cnt_clr
);
  localparam int PRG_W = $clog2(PAT_W+1);
  localparam logic [PRG_W-1:0] FILL_MAX = PRG_W'(PAT_W);
  localparam logic [PRG_W-1:0] FILL_ARM = PRG_W'(PAT_W-1);
  logic [PAT_W-1:0] r_pat, r_hist, w_next;
  logic [PRG_W-1:0] r_fill;
  logic             r_match, w_acc, w_hit;
  // fill gating keeps stale zeros in history from matching an all-zero pattern
  always_comb begin
    w_next = {r_hist[PAT_W-2:0], in_bit};
    w_acc  = in_valid & ~cfg_load;
    w_hit  = w_acc & (r_fill >= FILL_ARM) & (w_next == r_pat);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat   <= PAT_RESET;
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else if (cfg_load) begin
      r_pat   <= cfg_pattern;
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else begin
      r_match <= w_hit;
      if (w_acc) begin
        if (w_hit && !OVERLAP) begin
          r_hist <= '0;
          r_fill <= '0;
        end else begin
          r_hist <= w_next;
          r_fill <= (r_fill == FILL_MAX) ? r_fill : r_fill + PRG_W'(1);
        end
      end
    end
  end
  assign match    = r_match;
  assign progress = r_fill;
`ifdef SEQ_PATTERN_DETECTOR_MATCH_COUNT_EN
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) r_cnt <= '0;
    else if (w_hit && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
  end
  assign match_count = r_cnt;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr;
  assign match_count = '0;
`endif
endmodule
